// File: rtl/draw_sink.sv
// rtl/draw_sink.sv - drawer-to-framebuffer sink: frame FSM, clipping, show-ahead write FIFO.
// Optional pixel counter enabled by defining DRAW_SINK_COUNT_EN.
module draw_sink #(
    parameter int FIFO_DEPTH    = 8,
    parameter int ADDR_WIDTH    = 15,
    parameter int X_COORD_WIDTH = 8,
    parameter int Y_COORD_WIDTH = 7,
    parameter int COLOUR_WIDTH  = 3,
    parameter int SCREEN_WIDTH  = 160,
    parameter int SCREEN_HEIGHT = 120
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     req,
    output logic                     start,
    input  logic [X_COORD_WIDTH-1:0] in_x,
    input  logic [Y_COORD_WIDTH-1:0] in_y,
    input  logic [COLOUR_WIDTH-1:0]  in_colour,
    input  logic                     in_plot,
    input  logic                     in_finished,
    output logic [ADDR_WIDTH-1:0]    fb_addr,
    output logic [COLOUR_WIDTH-1:0]  fb_data,
    output logic                     fb_we,
    input  logic                     fb_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
    output logic [ADDR_WIDTH:0]      pixel_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;
    logic   pending_q, pending_d;
    logic   captured_q, captured_d;
    logic   overflow_q, overflow_d;

    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        count_q;
    logic [ADDR_WIDTH-1:0]   addr_mem_q   [FIFO_DEPTH];
    logic [COLOUR_WIDTH-1:0] colour_mem_q [FIFO_DEPTH];

    logic                  frame_go;
    logic                  capture;
    logic                  in_range;
    logic                  push;
    logic                  pop;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [ADDR_WIDTH-1:0] addr_calc;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop        = !fifo_empty && fb_ready;
    assign capture    = (state_q == S_STREAM) && in_plot && !in_finished;
    assign in_range   = (32'(in_x) < 32'(SCREEN_WIDTH)) && (32'(in_y) < 32'(SCREEN_HEIGHT));
    // A full FIFO still accepts a pixel when the head leaves in the same cycle.
    assign push       = capture && in_range && (!fifo_full || pop);
    assign addr_calc  = ADDR_WIDTH'(in_y) * ADDR_WIDTH'(SCREEN_WIDTH) + ADDR_WIDTH'(in_x);
    assign frame_go   = (state_q == S_IDLE) && (req || pending_q) && in_finished;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (frame_go) state_d = S_START;
            S_START:  state_d = S_STREAM;
            S_STREAM: if (captured_q && in_finished) state_d = S_DRAIN;
            S_DRAIN:  if (fifo_empty) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pending_d  = 1'b0;
        captured_d = captured_q;
        overflow_d = overflow_q;
        if (state_q == S_IDLE) begin
            pending_d = !frame_go && (pending_q || req);
        end
        if (frame_go) begin
            captured_d = 1'b0;
            overflow_d = 1'b0;
        end
        if (capture) begin
            captured_d = 1'b1;
        end
        if (capture && in_range && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            pending_q  <= 1'b0;
            captured_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            captured_q <= captured_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: occupancy gates everything visible at the outputs.
    always_ff @(posedge clock) begin
        if (push) begin
            addr_mem_q[wr_ptr_q]   <= addr_calc;
            colour_mem_q[wr_ptr_q] <= in_colour;
        end
    end

`ifdef DRAW_SINK_COUNT_EN
    logic [ADDR_WIDTH:0] pix_cnt_q;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            pix_cnt_q <= '0;
        end else if (frame_go) begin
            pix_cnt_q <= '0;
        end else if (pop) begin
            pix_cnt_q <= pix_cnt_q + (ADDR_WIDTH+1)'(1);
        end
    end

    assign pixel_count = pix_cnt_q;
`else
    assign pixel_count = '0;
`endif

    assign fb_we    = !fifo_empty;
    assign fb_addr  = fifo_empty ? '0 : addr_mem_q[rd_ptr_q];
    assign fb_data  = fifo_empty ? '0 : colour_mem_q[rd_ptr_q];
    assign start    = (state_q == S_START);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign overflow = overflow_q;

endmodule

// File: doc/draw_sink.md
DRAW_SINK -- requirements
Module: draw_sink

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, pixel buffer entries (power of two, >=2).
REQ-002 Parameter ADDR_WIDTH, default 15, framebuffer address width.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 req  input  1  frame request from top level; one-cycle or held level.
REQ-006 start  output  1  start strobe to the drawer.
REQ-007 in_x  input  X_COORD_WIDTH  drawer x coordinate.
REQ-008 in_y  input  Y_COORD_WIDTH  drawer y coordinate.
REQ-009 in_colour  input  COLOUR_WIDTH  drawer colour.
REQ-010 in_plot  input  1  drawer plot qualifier.
REQ-011 in_finished  input  1  drawer finished flag.
REQ-012 fb_addr  output  ADDR_WIDTH  framebuffer write address.
REQ-013 fb_data  output  COLOUR_WIDTH  framebuffer write data.
REQ-014 fb_we  output  1  write valid.
REQ-015 fb_ready  input  1  framebuffer accepts the write this cycle.
REQ-016 busy  output  1  high outside IDLE.
REQ-017 done  output  1  one-cycle pulse at frame completion.
REQ-018 overflow  output  1  sticky pixel-lost flag.
REQ-019 pixel_count  output  ADDR_WIDTH+1  pixels written in the current/last frame.

Function
REQ-020 FSM states: IDLE, START, STREAM, DRAIN, DONE.
REQ-021 IDLE: if req=1 and in_finished=1, go to START and clear overflow and pixel_count; if req=1 and in_finished=0, remain IDLE and keep the request pending until in_finished=1.
REQ-022 START: start=1 for exactly one cycle; go to STREAM.
REQ-023 STREAM: capture a pixel on every cycle with in_plot=1 and in_finished=0; the first cycle of STREAM always has in_finished=1 and captures nothing.
REQ-024 STREAM exits to DRAIN on the first cycle after at least one capture on which in_finished=1.
REQ-025 DRAIN: go to DONE when the FIFO is empty and no write is outstanding.
REQ-026 DONE: done=1 for one cycle; go to IDLE; req is ignored in DONE.
REQ-027 Clipping: captured pixels with in_x>=SCREEN_WIDTH or in_y>=SCREEN_HEIGHT are discarded, not pushed.
REQ-028 Address = in_y*SCREEN_WIDTH+in_x, computed at capture, truncated to ADDR_WIDTH, stored with colour in the FIFO.
REQ-029 FIFO is show-ahead: fb_we=1 whenever non-empty; fb_addr/fb_data show the head entry and hold stable while fb_we=1 and fb_ready=0.
REQ-030 Pop on fb_we=1 and fb_ready=1; pixel_count increments on each pop.
REQ-031 Push when full is permitted only if a pop occurs the same cycle; otherwise the pixel is dropped and overflow is set to 1.
REQ-032 Simultaneous push and pop leaves occupancy unchanged; push into an empty FIFO is visible on fb_we the next cycle (latency 1 capture->fb_we).
REQ-033 req while busy=1 has no effect and is not queued.

Reset
REQ-034 resetn=0 at a clock edge forces IDLE, empties the FIFO, and clears any pending request.
REQ-035 During and after reset: start=0, fb_we=0, busy=0, done=0, overflow=0, pixel_count=0, fb_addr=0, fb_data=0.
REQ-036 Reset mid-frame discards buffered pixels with no further writes.

Configuration
REQ-037 Macro DRAW_SINK_COUNT_EN: when defined, pixel_count behaves per REQ-030; when undefined, no counter is built and pixel_count is constant 0.

Verification
(SCREEN_WIDTH=160, SCREEN_HEIGHT=120, FIFO_DEPTH=8, fb_ready=1 unless stated.)
REQ-038 Drawer idle with finished=1; req pulse -> start high one cycle; 19200 writes with addresses 0..19199 in order; done pulses once; pixel_count=19200; overflow=0.
REQ-039 fb_ready low for 5 cycles once every 8 cycles -> overflow=1; fb_addr/fb_data stable during every stall; done still pulses.
REQ-040 req while in_finished=0 -> start withheld until in_finished=1, then issued exactly once.
REQ-041 Drawer pixel x=170,y=10 -> no write; x=159,y=119 -> write to address 19199.
REQ-042 resetn low for one cycle mid-STREAM with 4 pixels buffered -> fb_we=0 on the next cycle; busy=0; no done pulse.
REQ-043 req held high through DONE -> exactly one new start, issued only after IDLE is re-entered.
